// File: rtl/jtl_timing_pkg.sv
// rtl/jtl_timing_pkg.sv - shared lane states, tick type and default timing constants for the JTL delay line
package jtl_timing_pkg;

    localparam int DEFAULT_DELAY_TICKS  = 45;
    localparam int DEFAULT_CT_TICKS     = 50;
    localparam int DEFAULT_WARMUP_TICKS = 40;
    localparam int DEFAULT_DEPTH        = 4;
    localparam int DEFAULT_TW           = 8;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        READY   = 2'd1,
        BLOCKED = 2'd2,
        ERROR   = 2'd3
    } lane_state_e;

    typedef logic [DEFAULT_TW-1:0] tick_t;

endpackage

// File: rtl/jtl_lane.sv
// rtl/jtl_lane.sv - one JTL lane: state machine, critical-timing counter and release-timestamp FIFO
module jtl_lane
    import jtl_timing_pkg::*;
#(
    parameter int DELAY_TICKS  = DEFAULT_DELAY_TICKS,
    parameter int CT_TICKS     = DEFAULT_CT_TICKS,
    parameter int WARMUP_TICKS = DEFAULT_WARMUP_TICKS,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int TW           = DEFAULT_TW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] now,
    input  logic          pulse,
    input  logic          err_clr,
    output logic          out,
    output logic          out_unk,
    output logic          viol
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(CT_TICKS + 2);

    localparam logic [TW-1:0] DELAY_T  = TW'(DELAY_TICKS);
    localparam logic [TW-1:0] WARMUP_T = TW'(WARMUP_TICKS);
    localparam logic [CW-1:0] CT_T     = CW'(CT_TICKS);
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(DEPTH);

    lane_state_e   state_q, state_d;
    logic [CW-1:0] ct_q, ct_d;
    logic [TW-1:0] mem_q [DEPTH];
    logic [TW-1:0] mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          out_q, out_d;

    logic          pop;
    logic          push;
    logic [PW:0]   cnt_post;

    always_comb begin
        state_d  = state_q;
        ct_d     = ct_q;
        mem_d    = mem_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        viol     = 1'b0;
        push     = 1'b0;
        pop      = (cnt_q != '0) && (mem_q[rd_q] == now);
        cnt_post = cnt_q - {{PW{1'b0}}, pop};

        case (state_q)
            WARMUP: begin
                if (now == WARMUP_T) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (pulse) begin
                    // Fullness is judged after this cycle's release so a same-cycle pop frees a slot.
                    if (cnt_post == DEPTH_C) begin
                        viol = 1'b1;
                    end else begin
                        push = 1'b1;
                        ct_d = CT_T;
                        if (CT_TICKS > 0) begin
                            state_d = BLOCKED;
                        end
                    end
                end
            end
            BLOCKED: begin
                if (pulse) begin
                    viol = 1'b1;
                end else begin
                    ct_d = ct_q - CW'(1);
                    if (ct_q == CW'(1)) begin
                        state_d = READY;
                    end
                end
            end
            ERROR: begin
                if (err_clr) begin
                    state_d = READY;
                end
            end
            default: state_d = WARMUP;
        endcase

        // A violation freezes the output and discards everything in flight, including a due release.
        if (viol) begin
            state_d = ERROR;
            ct_d    = '0;
            rd_d    = '0;
            wr_d    = '0;
            cnt_d   = '0;
        end else begin
            if (pop) begin
                rd_d  = rd_q + PW'(1);
                out_d = ~out_q;
            end
            if (push) begin
                mem_d[wr_q] = now + DELAY_T;
                wr_d        = wr_q + PW'(1);
            end
            cnt_d = cnt_post + {{PW{1'b0}}, push};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WARMUP;
            ct_q    <= '0;
            mem_q   <= '{default: '0};
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ct_q    <= ct_d;
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out     = out_q;
    assign out_unk = (state_q == ERROR);

endmodule

// File: rtl/jtl_delay_line_mc.sv
// rtl/jtl_delay_line_mc.sv - multi-channel SFQ JTL delay-line timing model; JTL_ERR_LOG_EN adds a violation log
module jtl_delay_line_mc
    import jtl_timing_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int DELAY_TICKS  = DEFAULT_DELAY_TICKS,
    parameter int CT_TICKS     = DEFAULT_CT_TICKS,
    parameter int WARMUP_TICKS = DEFAULT_WARMUP_TICKS,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int TW           = DEFAULT_TW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] lane_en,
    input  logic [CHANNELS-1:0] in,
    input  logic                err_clr,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] out_unk,
    output logic                err_any,
    output logic [15:0]         err_cnt
);

    logic [TW-1:0]       now_q, now_d;
    logic [CHANNELS-1:0] in_q, in_d;
    logic [15:0]         err_cnt_q, err_cnt_d;

    logic [CHANNELS-1:0] edge_det;
    logic [CHANNELS-1:0] viol;
    logic [16:0]         viol_sum;
    logic [16:0]         err_total;

    assign edge_det = in ^ in_q;

    always_comb begin
        now_d    = now_q + TW'(1);
        in_d     = in;
        viol_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            viol_sum = viol_sum + {16'd0, viol[i]};
        end
        err_total = {1'b0, err_cnt_q} + viol_sum;
        err_cnt_d = err_total[16] ? 16'hFFFF : err_total[15:0];
    end

    // in_q is loaded from the live input during reset so a held level never looks like a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q     <= '0;
            in_q      <= in;
            err_cnt_q <= '0;
        end else begin
            now_q     <= now_d;
            in_q      <= in_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        jtl_lane #(
            .DELAY_TICKS  (DELAY_TICKS),
            .CT_TICKS     (CT_TICKS),
            .WARMUP_TICKS (WARMUP_TICKS),
            .DEPTH        (DEPTH),
            .TW           (TW)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .now     (now_q),
            .pulse   (edge_det[g] & lane_en[g]),
            .err_clr (err_clr),
            .out     (out[g]),
            .out_unk (out_unk[g]),
            .viol    (viol[g])
        );
    end

    assign err_any = |out_unk;
    assign err_cnt = err_cnt_q;

`ifdef JTL_ERR_LOG_EN
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (viol[i]) begin
                    $display("Violation of critical timing in module %m lane %0d; %0d ticks.", i, now_q);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_jtl_delay_line_mc.sv
// tb/tb_jtl_delay_line_mc.sv - directed self-checking bench for jtl_delay_line_mc (default lanes and CT_TICKS=10 lanes)
module tb_jtl_delay_line_mc;

    logic        clk;
    logic        rst_n;
    logic        err_clr;
    logic [3:0]  lane_en_a, in_a, out_a, out_unk_a;
    logic [3:0]  lane_en_b, in_b, out_b, out_unk_b;
    logic        err_any_a, err_any_b;
    logic [15:0] err_cnt_a, err_cnt_b;

    int n_checks = 0;
    int n_errors = 0;
    int tb_tick;

    jtl_delay_line_mc u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .lane_en (lane_en_a),
        .in      (in_a),
        .err_clr (err_clr),
        .out     (out_a),
        .out_unk (out_unk_a),
        .err_any (err_any_a),
        .err_cnt (err_cnt_a)
    );

    jtl_delay_line_mc #(.CT_TICKS(10)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .lane_en (lane_en_b),
        .in      (in_b),
        .err_clr (err_clr),
        .out     (out_b),
        .out_unk (out_unk_b),
        .err_any (err_any_b),
        .err_cnt (err_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute tick reference: zero in reset, +1 per clock, not wrapped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_tick <= 0;
        else        tb_tick <= tb_tick + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go_to(input int t);
        while (tb_tick < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        err_clr   = 1'b0;
        in_a      = 4'h0;
        in_b      = 4'h0;
        lane_en_a = 4'hF;
        lane_en_b = 4'hF;
        #2;
        check("rst_out_a",     {28'd0, out_a},     32'd0);
        check("rst_unk_a",     {28'd0, out_unk_a}, 32'd0);
        check("rst_any_a",     {31'd0, err_any_a}, 32'd0);
        check("rst_cnt_a",     {16'd0, err_cnt_a}, 32'd0);
        check("rst_out_b",     {28'd0, out_b},     32'd0);
        #20;
        rst_n = 1'b1;

        go_to(10);  in_a[1] = ~in_a[1];
        go_to(60);
        check("warm_no_out",   {31'd0, out_a[1]},  32'd0);
        check("warm_no_err",   {16'd0, err_cnt_a}, 32'd0);
        in_a[1] = ~in_a[1];

        go_to(100);
        in_a[0] = ~in_a[0];
        in_a[2] = ~in_a[2];
        in_b[2:0] = ~in_b[2:0];
        go_to(105); check("warm_pre",      {31'd0, out_a[1]},  32'd0);
        go_to(106); check("warm_toggle",   {31'd0, out_a[1]},  32'd1);
        go_to(111); in_b[2:0] = ~in_b[2:0];
        go_to(122); in_b[2:0] = ~in_b[2:0];
        go_to(130);
        check("ct_pre_unk",    {31'd0, out_unk_a[2]}, 32'd0);
        in_a[2] = ~in_a[2];
        go_to(131);
        check("ct_unk",        {31'd0, out_unk_a[2]}, 32'd1);
        check("ct_cnt",        {16'd0, err_cnt_a},    32'd1);
        check("ct_any",        {31'd0, err_any_a},    32'd1);
        go_to(133); in_b[2:0] = ~in_b[2:0];
        go_to(144);
        check("ovf_pre_unk",   {31'd0, out_unk_b[1]}, 32'd0);
        in_b[1] = ~in_b[1];
        go_to(145);
        in_b[2] = ~in_b[2];
        check("single_pre",    {31'd0, out_a[0]},     32'd0);
        check("ovf_unk",       {31'd0, out_unk_b[1]}, 32'd1);
        check("ovf_cnt",       {16'd0, err_cnt_b},    32'd1);
        check("pushpop_pre",   {31'd0, out_b[2]},     32'd0);
        go_to(146);
        check("single_toggle", {31'd0, out_a[0]},  32'd1);
        check("ct_flushed",    {31'd0, out_a[2]},  32'd0);
        check("ovl_146",       {31'd0, out_b[0]},  32'd1);
        check("ovf_flushed",   {31'd0, out_b[1]},  32'd0);
        check("pushpop_146",   {31'd0, out_b[2]},  32'd1);

        go_to(150); err_clr = 1'b1;
        go_to(151);
        err_clr = 1'b0;
        check("clr_unk_a",     {31'd0, out_unk_a[2]}, 32'd0);
        check("clr_any_a",     {31'd0, err_any_a},    32'd0);
        check("clr_cnt_keep",  {16'd0, err_cnt_a},    32'd1);
        check("clr_unk_b",     {31'd0, out_unk_b[1]}, 32'd0);

        go_to(157); check("ovl_157",       {31'd0, out_b[0]},  32'd0);
        go_to(160); in_a[2] = ~in_a[2];
        go_to(168); check("ovl_168",       {31'd0, out_b[0]},  32'd1);
        go_to(179);
        check("ovl_179",       {31'd0, out_b[0]},  32'd0);
        check("pushpop_179",   {31'd0, out_b[2]},  32'd0);
        go_to(190); check("pushpop_190",   {31'd0, out_b[2]},  32'd0);
        go_to(191);
        check("pushpop_191",   {31'd0, out_b[2]},  32'd1);
        check("pushpop_nocnt", {16'd0, err_cnt_b}, 32'd1);

        go_to(200);
        lane_en_a[3] = 1'b0;
        in_a[3] = ~in_a[3];
        go_to(206); check("clr_reaccept",  {31'd0, out_a[2]},  32'd1);
        go_to(210); lane_en_a[3] = 1'b1;
        go_to(247); check("dis_ignored",   {31'd0, out_a[3]},  32'd0);
        go_to(250); in_a[3] = ~in_a[3];
        go_to(295); check("wrap_pre",      {31'd0, out_a[3]},  32'd0);
        go_to(296); check("wrap_toggle",   {31'd0, out_a[3]},  32'd1);

        go_to(300); in_a[0] = ~in_a[0];
        go_to(310); lane_en_a[0] = 1'b0;
        go_to(345); check("en_off_pre",    {31'd0, out_a[0]},  32'd1);
        go_to(346);
        check("en_off_deliver", {31'd0, out_a[0]},  32'd0);
        check("cnt_total_a",    {16'd0, err_cnt_a}, 32'd1);

        go_to(400); in_b[3] = ~in_b[3];
        go_to(411); in_b[3] = ~in_b[3];
        go_to(422); in_b[3] = ~in_b[3];
        go_to(430);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_b", {28'd0, out_b},     32'd0);
        check("mid_rst_out_a", {28'd0, out_a},     32'd0);
        check("mid_rst_cnt_a", {16'd0, err_cnt_a}, 32'd0);
        check("mid_rst_cnt_b", {16'd0, err_cnt_b}, 32'd0);
        #20;
        rst_n = 1'b1;
        go_to(60);  check("post_rst_60",  {28'd0, out_b}, 32'd0);
        go_to(200);
        check("post_rst_200", {28'd0, out_b},     32'd0);
        check("post_rst_cnt", {16'd0, err_cnt_b}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
